// File: rtl/pattern_source_gen.sv
// Test-pattern source for the serial-link test path: counter, PRBS and constant
// generators behind a debounced mode select, with hold and single-word error injection.
`timescale 1ns/1ps

module pattern_source_gen #(
  parameter int                WIDTH         = 16,
  parameter int                PRBS_ORDER    = 7,
  parameter logic [WIDTH-1:0]  CONST_PATTERN = WIDTH'(16'hA5A5),
  parameter int                SEL_STABLE    = 1024
) (
  input  logic             clk1280,
  input  logic             rst,
  input  logic [1:0]       sel,
  input  logic             inj_err,
  input  logic             hold,
  output logic [WIDTH-1:0] source_out,
  output logic [1:0]       mode,
  output logic             mode_change,
  output logic [7:0]       err_count
);

  typedef enum logic [1:0] {
    MODE_CNT   = 2'd0,
    MODE_PRBS  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_INV   = 2'd3
  } mode_e;

  // Second feedback tap; the first is always the MSB of the LFSR.
  localparam int TAP_B = (PRBS_ORDER == 7)  ? 5  :
                         (PRBS_ORDER == 15) ? 13 :
                         (PRBS_ORDER == 23) ? 17 : 27;

  localparam int             DB_W   = $clog2(SEL_STABLE);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(SEL_STABLE - 1);

  logic [1:0]            sel_sync1;
  logic [1:0]            sel_sync2;
  logic [1:0]            sel_cand;
  logic [DB_W-1:0]       db_cnt;
  logic [DB_W-1:0]       db_next;
  logic                  sel_diff;
  logic                  commit_now;

  logic [WIDTH-1:0]      cnt_q;
  logic [PRBS_ORDER-1:0] lfsr_q;
  logic [PRBS_ORDER-1:0] lfsr_adv;
  logic [WIDTH-1:0]      prbs_word;
  logic [WIDTH-1:0]      gen_word;
  logic                  inj_pend;
  logic                  flip_bit;

  // WIDTH LFSR steps per cycle; the first generated bit becomes the word MSB.
  always_comb begin
    logic [PRBS_ORDER-1:0] s;
    logic                  fb;
    s         = lfsr_q;
    fb        = 1'b0;
    prbs_word = '0;
    for (int i = 0; i < WIDTH; i++) begin
      fb                   = s[PRBS_ORDER-1] ^ s[TAP_B];
      prbs_word[WIDTH-1-i] = fb;
      s                    = {s[PRBS_ORDER-2:0], fb};
    end
    lfsr_adv = s;
  end

  always_comb begin
    gen_word = cnt_q;
    case (mode)
      MODE_CNT:   gen_word = cnt_q;
      MODE_PRBS:  gen_word = prbs_word;
      MODE_CONST: gen_word = CONST_PATTERN;
      MODE_INV:   gen_word = ~CONST_PATTERN;
    endcase
  end

  always_comb begin
    sel_diff   = (sel_sync2 != sel_cand);
    db_next    = (db_cnt == DB_MAX) ? DB_MAX : db_cnt + DB_W'(1);
    commit_now = !sel_diff && (db_next == DB_MAX) && (sel_cand != mode);
    // An injection that lands on a commit edge is deferred to the first new-mode word.
    flip_bit   = !commit_now && (inj_err || inj_pend);
  end

  always_ff @(posedge clk1280) begin
    if (rst) begin
      sel_sync1   <= '0;
      sel_sync2   <= '0;
      sel_cand    <= '0;
      db_cnt      <= '0;
      mode        <= MODE_CNT;
      mode_change <= 1'b0;
      cnt_q       <= '0;
      lfsr_q      <= '1;
      source_out  <= '0;
      inj_pend    <= 1'b0;
      err_count   <= '0;
    end else begin
      sel_sync1 <= sel;
      sel_sync2 <= sel_sync1;

      if (sel_diff) begin
        sel_cand <= sel_sync2;
        db_cnt   <= '0;
      end else if (commit_now) begin
        db_cnt   <= '0;
      end else begin
        db_cnt   <= db_next;
      end

      mode_change <= commit_now;
      if (commit_now) begin
        mode <= sel_cand;
      end

      if (commit_now) begin
        cnt_q  <= '0;
        lfsr_q <= '1;
      end else if (!hold) begin
        cnt_q  <= cnt_q + WIDTH'(1);
        lfsr_q <= lfsr_adv;
      end

      source_out <= gen_word ^ {{(WIDTH-1){1'b0}}, flip_bit};
      inj_pend   <= commit_now && inj_err;

      if (inj_err && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_source_gen.sv
// Scoreboard bench for pattern_source_gen: a cycle model pushes expected outputs
// as each input set is driven; they are popped and compared after the clock edge.
`timescale 1ns/1ps

module tb_pattern_source_gen;

  localparam int SS = 8;

  logic        clk1280 = 1'b0;
  logic        rst     = 1'b1;
  logic [1:0]  sel     = 2'd0;
  logic        inj_err = 1'b0;
  logic        hold    = 1'b0;
  logic [15:0] source_out;
  logic [1:0]  mode;
  logic        mode_change;
  logic [7:0]  err_count;

  pattern_source_gen #(
    .WIDTH        (16),
    .PRBS_ORDER   (7),
    .CONST_PATTERN(16'hA5A5),
    .SEL_STABLE   (SS)
  ) dut (
    .clk1280    (clk1280),
    .rst        (rst),
    .sel        (sel),
    .inj_err    (inj_err),
    .hold       (hold),
    .source_out (source_out),
    .mode       (mode),
    .mode_change(mode_change),
    .err_count  (err_count)
  );

  always #5 clk1280 = ~clk1280;

  typedef struct {
    logic [15:0] out;
    logic [1:0]  mode;
    logic        mc;
    logic [7:0]  err;
  } exp_t;

  exp_t exp_q[$];

  int n_chk = 0;
  int n_err = 0;
  int mc_cnt = 0;

  // model state
  logic [1:0]  m_s1, m_s2, m_cand, m_mode;
  int          m_run;
  logic [15:0] m_ctr;
  logic [6:0]  m_lfsr;
  logic        m_pend;
  int          m_err;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] prbs16(input logic [6:0] st, output logic [6:0] nst);
    logic [15:0] w;
    logic        b;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      b         = st[6] ^ st[5];
      w[15 - i] = b;
      st        = {st[5:0], b};
    end
    nst = st;
    return w;
  endfunction

  task automatic model_edge(input logic r, input logic [1:0] s, input logic inj, input logic h);
    exp_t        e;
    logic [15:0] word, pw;
    logic [6:0]  nl;
    logic        commit, flip;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_cand = 0; m_run = 0; m_mode = 0;
      m_ctr = 0; m_lfsr = '1; m_pend = 0; m_err = 0;
      e.out = 0; e.mode = 0; e.mc = 0; e.err = 0;
    end else begin
      pw = prbs16(m_lfsr, nl);
      case (m_mode)
        2'd0:    word = m_ctr;
        2'd1:    word = pw;
        2'd2:    word = 16'hA5A5;
        default: word = 16'h5A5A;
      endcase
      commit = 0;
      if (m_s2 != m_cand) begin
        m_cand = m_s2;
        m_run  = 0;
      end else begin
        if (m_run < SS - 1) m_run++;
        if (m_run == SS - 1 && m_cand != m_mode) begin
          commit = 1;
          m_run  = 0;
        end
      end
      flip   = !commit && (inj || m_pend);
      m_pend = commit && inj;
      e.out  = word ^ {15'd0, flip};
      e.mc   = commit;
      if (commit) begin
        m_mode = m_cand;
        m_ctr  = 0;
        m_lfsr = '1;
      end else if (!h) begin
        m_ctr  = m_ctr + 16'd1;
        m_lfsr = nl;
      end
      if (inj && m_err < 255) m_err++;
      m_s2 = m_s1;
      m_s1 = s;
      e.mode = m_mode;
      e.err  = 8'(m_err);
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic [1:0] s, input logic i, input logic h);
    exp_t e;
    rst = r; sel = s; inj_err = i; hold = h;
    model_edge(r, s, i, h);
    @(posedge clk1280);
    #1;
    e = exp_q.pop_front();
    check_eq("out",  64'(source_out),  64'(e.out));
    check_eq("mode", 64'(mode),        64'(e.mode));
    check_eq("mchg", 64'(mode_change), 64'(e.mc));
    check_eq("errc", 64'(err_count),   64'(e.err));
    if (mode_change) mc_cnt++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    @(posedge clk1280);
    #1;
    step(1, 0, 0, 0);
    step(1, 0, 1, 1);
    check_eq("rst_out",  64'(source_out), 64'h0);
    check_eq("rst_mode", 64'(mode),       64'h0);
    check_eq("rst_err",  64'(err_count),  64'h0);

    // counter start
    step(0, 0, 0, 0); check_eq("cnt0", 64'(source_out), 64'h0000);
    step(0, 0, 0, 0); check_eq("cnt1", 64'(source_out), 64'h0001);
    step(0, 0, 0, 0); check_eq("cnt2", 64'(source_out), 64'h0002);

    // hold with injection
    n = 0;
    while (m_ctr != 16'h0010 && n < 100) begin step(0, 0, 0, 0); n++; end
    for (int k = 0; k < 5; k++) begin
      step(0, 0, k == 2, 1);
      check_eq(k == 2 ? "hold_inj" : "hold_out", 64'(source_out), k == 2 ? 64'h0011 : 64'h0010);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0); check_eq("hold_resume", 64'(source_out), 64'h0011);

    // counter wrap
    n = 0;
    while (m_ctr != 16'hFFFF && n < 70000) begin step(0, 0, 0, 0); n++; end
    step(0, 0, 0, 0); check_eq("wrap_ffff", 64'(source_out), 64'hFFFF);
    step(0, 0, 0, 0); check_eq("wrap_0000", 64'(source_out), 64'h0000);

    // switch to PRBS
    mc_cnt = 0;
    n = 0;
    do begin step(0, 1, 0, 0); n++; end while (mode != 2'd1 && n < SS + 20);
    check_eq("sw1_lat", 64'(n), 64'(SS + 2));
    step(0, 1, 0, 0); check_eq("prbs_first", 64'(source_out), 64'h020C);
    for (int j = 1; j <= 127; j++) step(0, 1, j == 50, 0);
    check_eq("prbs_period", 64'(source_out), 64'h020C);
    check_eq("sw1_pulses", 64'(mc_cnt), 64'd1);

    // switch to constant with injection on the commit edge
    for (int k = 1; k <= SS + 2; k++) step(0, 2, k == SS + 2, 0);
    check_eq("sw2_mode", 64'(mode), 64'd2);
    step(0, 2, 0, 0); check_eq("inj_commit", 64'(source_out), 64'hA5A4);
    step(0, 2, 0, 0); check_eq("const", 64'(source_out), 64'hA5A5);

    n = 0;
    do begin step(0, 3, 0, 0); n++; end while (mode != 2'd3 && n < SS + 20);
    step(0, 3, 0, 0); check_eq("inv", 64'(source_out), 64'h5A5A);

    // glitch shorter than the debounce window
    mc_cnt = 0;
    for (int k = 0; k < SS - 1; k++) step(0, 0, 0, 0);
    for (int k = 0; k < 20; k++) step(0, 3, 0, 0);
    check_eq("glitch_mc",   64'(mc_cnt), 64'd0);
    check_eq("glitch_mode", 64'(mode),   64'd3);

    // error counter saturation
    for (int k = 0; k < 600; k++) step(0, 3, (k % 2) == 0, 0);
    check_eq("err_sat", 64'(err_count), 64'd255);

    // reset in the middle of PRBS and of a debounce
    n = 0;
    do begin step(0, 1, 0, 0); n++; end while (mode != 2'd1 && n < SS + 20);
    for (int k = 0; k < 10; k++) step(0, 1, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 2, 0, 0);
    step(1, 2, 1, 1);
    check_eq("mid_rst_out",  64'(source_out),  64'h0);
    check_eq("mid_rst_mode", 64'(mode),        64'h0);
    check_eq("mid_rst_mc",   64'(mode_change), 64'h0);
    check_eq("mid_rst_err",  64'(err_count),   64'h0);
    step(0, 0, 0, 0); check_eq("post_rst0", 64'(source_out), 64'h0000);
    step(0, 0, 0, 0); check_eq("post_rst1", 64'(source_out), 64'h0001);
    for (int k = 0; k < 2 * SS; k++) step(0, 0, 0, 0);
    check_eq("post_rst_mode", 64'(mode), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
